carrega_matrizes: RTL and testbench

CARREGA_MATRIZES -- requirements
Module: carrega_matrizes

---
 rtl/carrega_matrizes.sv | 138 +++++++++++++
 tb/tb_carrega_matrizes.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/carrega_matrizes.sv
// carrega_matrizes: loads two 5x5 int8 matrices (A then B) from a byte memory
// with one read per cycle and a one-cycle read latency.
// Optional feature macro: CARREGA_TAMANHO_EN adds the tamanho port (dimension N, 2..5).
module carrega_matrizes (
`ifdef CARREGA_TAMANHO_EN
  input  logic [2:0]   tamanho,
`endif
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_carga,
  input  logic [7:0]   end_a,
  input  logic [7:0]   end_b,
  output logic         mem_rd,
  output logic [7:0]   mem_addr,
  input  logic [7:0]   mem_data,
  output logic [199:0] matrizA,
  output logic [199:0] matrizB,
  output logic         busy,
  output logic         done_carga
);

  localparam int unsigned DIM_MAX  = 5;
  localparam int unsigned ROW_BITS = 40;
  localparam int unsigned ELM_BITS = 8;

  typedef enum logic [2:0] {IDLE, LE_A, LE_B, DRENA, FIM} state_t;

  state_t     r_state;
  logic [2:0] r_row;
  logic [2:0] r_col;
  logic [7:0] r_end_b;
  logic       r_wr_en;
  logic       r_wr_sel;
  logic [2:0] r_wr_row;
  logic [2:0] r_wr_col;
  logic [2:0] w_nm1;
  logic       w_last;
  logic [7:0] w_off;

`ifdef CARREGA_TAMANHO_EN
  logic [2:0] r_nm1;
  // Dimension minus one, latched at start acceptance
  assign w_nm1 = r_nm1;
`else
  // Fixed dimension minus one
  assign w_nm1 = 3'(DIM_MAX - 1);
`endif

  // Last element of the current matrix is being read this cycle
  assign w_last = (r_row == w_nm1) && (r_col == w_nm1);
  // Bit offset of the element whose data is arriving this cycle
  assign w_off  = 8'(r_wr_row) * 8'(ROW_BITS) + 8'(r_wr_col) * 8'(ELM_BITS);

  // Load sequencer: state, read strobe/address, data write-back and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_row      <= 3'd0;
      r_col      <= 3'd0;
      r_end_b    <= 8'd0;
      r_wr_en    <= 1'b0;
      r_wr_sel   <= 1'b0;
      r_wr_row   <= 3'd0;
      r_wr_col   <= 3'd0;
      mem_rd     <= 1'b0;
      mem_addr   <= 8'd0;
      matrizA    <= 200'd0;
      matrizB    <= 200'd0;
      busy       <= 1'b0;
      done_carga <= 1'b0;
`ifdef CARREGA_TAMANHO_EN
      r_nm1      <= 3'(DIM_MAX - 1);
`endif
    end else begin
      // Data for the read issued last cycle is valid now
      r_wr_en  <= mem_rd;
      r_wr_sel <= (r_state == LE_B);
      r_wr_row <= r_row;
      r_wr_col <= r_col;
      if (r_wr_en) begin
        if (r_wr_sel) matrizB[w_off +: 8] <= mem_data;
        else          matrizA[w_off +: 8] <= mem_data;
      end

      case (r_state)
        IDLE: begin
          if (start_carga) begin
            r_state  <= LE_A;
            mem_rd   <= 1'b1;
            mem_addr <= end_a;
            r_end_b  <= end_b;
            r_row    <= 3'd0;
            r_col    <= 3'd0;
            matrizA  <= 200'd0;
            matrizB  <= 200'd0;
            busy     <= 1'b1;
`ifdef CARREGA_TAMANHO_EN
            r_nm1    <= (tamanho >= 3'd2 && tamanho <= 3'd5) ? tamanho - 3'd1
                                                             : 3'(DIM_MAX - 1);
`endif
          end
        end
        LE_A, LE_B: begin
          mem_addr <= mem_addr + 8'd1;
          if (r_col == w_nm1) begin
            r_col <= 3'd0;
            r_row <= r_row + 3'd1;
          end else begin
            r_col <= r_col + 3'd1;
          end
          if (w_last) begin
            r_row <= 3'd0;
            r_col <= 3'd0;
            if (r_state == LE_A) begin
              r_state  <= LE_B;
              mem_addr <= r_end_b;
            end else begin
              r_state  <= DRENA;
              mem_rd   <= 1'b0;
              mem_addr <= mem_addr;
            end
          end
        end
        DRENA: begin
          r_state    <= FIM;
          done_carga <= 1'b1;
        end
        FIM: begin
          r_state    <= IDLE;
          done_carga <= 1'b0;
          busy       <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_carrega_matrizes.sv
// Directed self-checking bench for carrega_matrizes with a byte memory model.
module tb_carrega_matrizes;

  logic         clk;
  logic         rst_n;
  logic         start_carga;
  logic [7:0]   end_a;
  logic [7:0]   end_b;
  logic         mem_rd;
  logic [7:0]   mem_addr;
  logic [7:0]   mem_data;
  logic [199:0] matrizA;
  logic [199:0] matrizB;
  logic         busy;
  logic         done_carga;
`ifdef CARREGA_TAMANHO_EN
  logic [2:0]   tamanho;
`endif

  logic [7:0] mem [256];
  int n_tot;
  int n_bad;

  carrega_matrizes dut (
`ifdef CARREGA_TAMANHO_EN
    .tamanho    (tamanho),
`endif
    .clk        (clk),
    .rst_n      (rst_n),
    .start_carga(start_carga),
    .end_a      (end_a),
    .end_b      (end_b),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .matrizA    (matrizA),
    .matrizB    (matrizB),
    .busy       (busy),
    .done_carga (done_carga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory: one-cycle read latency, garbage when not reading
  always @(posedge clk) mem_data <= mem_rd ? mem[mem_addr] : 8'hA5;

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Expected matrix image for dimension n read from base
  function automatic logic [199:0] model(input logic [7:0] base, input int n);
    logic [199:0] m;
    logic [7:0]   a;
    m = '0;
    for (int i = 0; i < n * n; i++) begin
      a = base + 8'(i);
      m[40 * (i / n) + 8 * (i % n) +: 8] = mem[a];
    end
    return m;
  endfunction

  // One full load from IDLE, checking every cycle up to a few past done
  task automatic do_load(input logic [7:0] ba, input logic [7:0] bb, input int n);
    logic [199:0] ea, eb;
    logic [7:0]   ex_addr;
    int nn, last;
    nn   = n * n;
    last = 2 * nn + 2;
    ea   = model(ba, n);
    eb   = model(bb, n);
    @(negedge clk);
    end_a = ba;
    end_b = bb;
    start_carga = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= last + 3; k++) begin
      @(negedge clk);
      start_carga = 1'b0;
      check($sformatf("rd_c%0d", k), 200'(mem_rd), 200'(k >= 1 && k <= 2 * nn));
      check($sformatf("busy_c%0d", k), 200'(busy), 200'(k <= last));
      check($sformatf("done_c%0d", k), 200'(done_carga), 200'(k == last));
      if (k <= nn)            ex_addr = ba + 8'(k - 1);
      else if (k <= 2 * nn)   ex_addr = bb + 8'(k - nn - 1);
      else                    ex_addr = bb + 8'(nn - 1);
      if (k <= last) check($sformatf("addr_c%0d", k), 200'(mem_addr), 200'(ex_addr));
      if (k == last) begin
        check("matA_done", matrizA, ea);
        check("matB_done", matrizB, eb);
      end
    end
    check("matA_hold", matrizA, ea);
    check("matB_hold", matrizB, eb);
  endtask

  initial begin
    int d1, d2, dcnt;
    n_tot = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start_carga = 1'b0;
    end_a = 8'd0;
    end_b = 8'd0;
`ifdef CARREGA_TAMANHO_EN
    tamanho = 3'd5;
`endif
    for (int x = 0; x < 256; x++) mem[x] = 8'(x);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd", 200'(mem_rd), 200'd0);
    check("rst_addr", 200'(mem_addr), 200'd0);
    check("rst_matA", matrizA, 200'd0);
    check("rst_matB", matrizB, 200'd0);
    check("rst_busy", 200'(busy), 200'd0);
    check("rst_done", 200'(done_carga), 200'd0);
    rst_n = 1'b1;

    // Basic load, identity memory
    do_load(8'h00, 8'h40, 5);
    check("basic_a23", 200'(matrizA[40*2+8*3 +: 8]), 200'd13);
    check("basic_b44", 200'(matrizB[192 +: 8]), 200'h58);

    // Address wrap past FF
    for (int x = 0; x < 256; x++) mem[x] = 8'(x) ^ 8'h3C;
    do_load(8'hF0, 8'h40, 5);
    check("wrap_a44", 200'(matrizA[192 +: 8]), 200'(8'h08 ^ 8'h3C));

    // start held high over cycles 0..60: two loads, done at 52 and 105
    d1 = 0; d2 = 0; dcnt = 0;
    @(negedge clk);
    end_a = 8'h00; end_b = 8'h40;
    start_carga = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 130; k++) begin
      @(negedge clk);
      if (k >= 61) start_carga = 1'b0;
      if (done_carga) begin
        dcnt++;
        if (dcnt == 1) d1 = k;
        if (dcnt == 2) d2 = k;
      end
    end
    check("held_dcnt", 200'(dcnt), 200'd2);
    check("held_d1", 200'(d1), 200'd52);
    check("held_d2", 200'(d2), 200'd105);

    // Reset mid-load aborts without done
    dcnt = 0;
    @(negedge clk);
    start_carga = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start_carga = 1'b0;
      if (done_carga) dcnt++;
    end
    rst_n = 1'b0;
    #1;
    check("mid_rd", 200'(mem_rd), 200'd0);
    check("mid_addr", 200'(mem_addr), 200'd0);
    check("mid_matA", matrizA, 200'd0);
    check("mid_matB", matrizB, 200'd0);
    check("mid_busy", 200'(busy), 200'd0);
    check("mid_done", 200'(done_carga), 200'd0);
    repeat (3) begin
      @(negedge clk);
      if (done_carga) dcnt++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done_carga) dcnt++;
    end
    check("mid_no_done", 200'(dcnt), 200'd0);
    for (int x = 0; x < 256; x++) mem[x] = 8'(x * 3);
    do_load(8'h05, 8'hA0, 5);

    // Zeros then all-ones: no stale bits
    for (int x = 0; x < 256; x++) mem[x] = 8'h00;
    do_load(8'h10, 8'h20, 5);
    check("zero_matA", matrizA, 200'd0);
    for (int x = 0; x < 256; x++) mem[x] = 8'hFF;
    do_load(8'h10, 8'h20, 5);
    check("ones_matA", matrizA, {200{1'b1}});
    check("ones_matB", matrizB, {200{1'b1}});

`ifdef CARREGA_TAMANHO_EN
    // Dimension 3: 9 reads per matrix, done in cycle 20
    for (int x = 0; x < 256; x++) mem[x] = 8'(x);
    tamanho = 3'd3;
    do_load(8'h20, 8'h60, 3);
    check("n3_a10", 200'(matrizA[40 +: 8]), 200'h23);
    check("n3_a30", 200'(matrizA[120 +: 8]), 200'd0);
    check("n3_a03", 200'(matrizA[24 +: 8]), 200'd0);
    tamanho = 3'd7;
    do_load(8'h00, 8'h40, 5);
    tamanho = 3'd5;
`endif

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
